// File: rtl/head_table_wr_sched_if.sv
// Head-table types plus the bundle between the insert/delete engines, the write scheduler and the head RAM write port.
// Master drives requests and clear; slave is the scheduler, which returns readies, the RAM write port and status.
package head_table_pkg;
   localparam int BUCKET_WIDTH = 10;
   localparam int ENTRY_WIDTH  = 12;

   typedef struct packed {
      logic [ENTRY_WIDTH-1:0] ptr;
      logic                   ptr_val;
   } head_ram_data_t;
endpackage

interface head_table_wr_sched_if #(
   parameter int A_WIDTH = head_table_pkg::BUCKET_WIDTH,
   parameter int D_WIDTH = $bits(head_table_pkg::head_ram_data_t)
);
   logic [A_WIDTH-1:0] req0_addr_i;
   logic [D_WIDTH-1:0] req0_data_i;
   logic               req0_valid_i;
   logic               req0_ready_o;

   logic [A_WIDTH-1:0] req1_addr_i;
   logic [D_WIDTH-1:0] req1_data_i;
   logic               req1_valid_i;
   logic               req1_ready_o;

   logic               clear_i;

   logic [A_WIDTH-1:0] wr_addr_o;
   logic [D_WIDTH-1:0] wr_data_o;
   logic               wr_en_o;

   logic               init_done_o;
   logic               busy_o;

   modport master (
      output req0_addr_i, req0_data_i, req0_valid_i,
      output req1_addr_i, req1_data_i, req1_valid_i,
      output clear_i,
      input  req0_ready_o, req1_ready_o,
      input  wr_addr_o, wr_data_o, wr_en_o,
      input  init_done_o, busy_o
   );

   modport slave (
      input  req0_addr_i, req0_data_i, req0_valid_i,
      input  req1_addr_i, req1_data_i, req1_valid_i,
      input  clear_i,
      output req0_ready_o, req1_ready_o,
      output wr_addr_o, wr_data_o, wr_en_o,
      output init_done_o, busy_o
   );
endinterface

// File: rtl/head_table_wr_sched.sv
// Head RAM write-port owner: zero sweep after reset/clear, then round-robin between insert and delete writers.
// Accepted request reaches the RAM port one cycle later; readies held low while sweeping, in reset and on a clear cycle.
module head_table_wr_sched #(
   parameter int A_WIDTH = head_table_pkg::BUCKET_WIDTH,
   parameter int D_WIDTH = $bits(head_table_pkg::head_ram_data_t)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   head_table_wr_sched_if.slave bus
);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   localparam logic [A_WIDTH:0] CNT_ONE  = {{A_WIDTH{1'b0}}, 1'b1};
   localparam logic [A_WIDTH:0] CNT_LAST = {1'b0, {A_WIDTH{1'b1}}};

   state_t             state_q, state_d;
   logic [A_WIDTH:0]   cnt_q, cnt_d;
   logic               last_grant_q, last_grant_d;
   logic               wr_en_q, wr_en_d;
   logic [A_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [D_WIDTH-1:0] wr_data_q, wr_data_d;
   logic               init_done_q, init_done_d;
   logic               gnt0, gnt1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_CLEAR;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         init_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         init_done_q  <= init_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      init_done_d  = init_done_q;
      gnt0         = 1'b0;
      gnt1         = 1'b0;

      case (state_q)
         S_CLEAR: begin
            // An empty bucket is the all-zero word: null pointer, valid bit clear.
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q[A_WIDTH-1:0];
            wr_data_d = '0;
            cnt_d     = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d     = S_RUN;
               cnt_d       = '0;
               init_done_d = 1'b1;
            end
         end
         S_RUN: begin
            if (bus.clear_i) begin
               state_d     = S_CLEAR;
               cnt_d       = '0;
               init_done_d = 1'b0;
            end else begin
               // On a tie, last_grant_q == 1 means requester 1 went last, so requester 0 goes now.
               gnt0 = bus.req0_valid_i && (!bus.req1_valid_i || last_grant_q);
               gnt1 = bus.req1_valid_i && (!bus.req0_valid_i || !last_grant_q);
               if (gnt0) begin
                  wr_en_d      = 1'b1;
                  wr_addr_d    = bus.req0_addr_i;
                  wr_data_d    = bus.req0_data_i;
                  last_grant_d = 1'b0;
               end else if (gnt1) begin
                  wr_en_d      = 1'b1;
                  wr_addr_d    = bus.req1_addr_i;
                  wr_data_d    = bus.req1_data_i;
                  last_grant_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.req0_ready_o = gnt0 && !rst_i;
   assign bus.req1_ready_o = gnt1 && !rst_i;
   assign bus.wr_en_o      = wr_en_q;
   assign bus.wr_addr_o    = wr_addr_q;
   assign bus.wr_data_o    = wr_data_q;
   assign bus.init_done_o  = init_done_q;
   assign bus.busy_o       = !init_done_q;

endmodule
